canvas_writer: RTL

- Downstream of the drawing controller. Consumes its drawPixel / clearCanvas pulses and drawX / drawY.
- Maps each pixel coordinate to a cell of the Game-of-Life grid. Issues single-bit writes to the cell-state RAM.
- Runs a full-grid clear sweep on request.
- Queues one draw that arrives while the block is busy, so no button press is lost during a clear.

---
 rtl/canvas_pkg.sv | 27 ++
 rtl/canvas_writer_if.sv | 29 ++
 rtl/cell_addr_map.sv | 21 ++
 rtl/canvas_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// Grid geometry, cell-address type and writer state encoding shared by the
// canvas writer and the Game-of-Life engine.
package canvas_pkg;

    localparam int CELL_SHIFT = 3;
    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int GRID_CELLS = GRID_W * GRID_H;
    localparam int ADDR_W     = 13;

    typedef logic [ADDR_W-1:0] cell_addr_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRAW_RD   = 3'd1,
        DRAW_WAIT = 3'd2,
        DRAW_WR   = 3'd3,
        CLEAR     = 3'd4
    } state_e;

    localparam cell_addr_t LAST_CELL = cell_addr_t'(GRID_CELLS - 1);

    function automatic logic is_last_cell(input cell_addr_t addr);
        return (addr == LAST_CELL);
    endfunction

endpackage

// File: rtl/canvas_writer_if.sv
// Request and cell-RAM bus of the canvas writer; slave is the writer side,
// master is the drawing controller / RAM environment side.
interface canvas_writer_if;
    import canvas_pkg::*;

    logic       drawPixel;
    logic       clearCanvas;
    logic [9:0] drawX;
    logic [8:0] drawY;
    logic       mem_rdata;
    logic       mem_we;
    logic       mem_re;
    cell_addr_t mem_addr;
    logic       mem_wdata;
    logic       busy;
    logic       clear_done;
    logic [7:0] drop_cnt;

    modport slave (
        input  drawPixel, clearCanvas, drawX, drawY, mem_rdata,
        output mem_we, mem_re, mem_addr, mem_wdata, busy, clear_done, drop_cnt
    );

    modport master (
        output drawPixel, clearCanvas, drawX, drawY, mem_rdata,
        input  mem_we, mem_re, mem_addr, mem_wdata, busy, clear_done, drop_cnt
    );

endinterface

// File: rtl/cell_addr_map.sv
// Pixel coordinate to Life-grid cell address; also used by the engine's
// display path, so it stays purely combinational.
module cell_addr_map
    import canvas_pkg::*;
(
    input  logic [9:0] draw_x_i,
    input  logic [8:0] draw_y_i,
    output cell_addr_t addr_o,
    output logic       in_range_o
);

    logic [9:0] cx_s;
    logic [8:0] cy_s;

    assign cx_s = draw_x_i >> CELL_SHIFT;
    assign cy_s = draw_y_i >> CELL_SHIFT;

    assign in_range_o = (cx_s < 10'(GRID_W)) && (cy_s < 9'(GRID_H));
    assign addr_o     = cell_addr_t'(cy_s) * cell_addr_t'(GRID_W) + cell_addr_t'(cx_s);

endmodule

// File: rtl/canvas_writer.sv
// Turns draw/clear pulses into single-bit cell-RAM writes, with one queued draw.
// Build option: DRAW_TOGGLE_EN makes draws read-modify-write toggles.
module canvas_writer
    import canvas_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    canvas_writer_if.slave bus
);

`ifdef DRAW_TOGGLE_EN
    localparam state_e SERVE_ST = DRAW_RD;
`else
    localparam state_e SERVE_ST = DRAW_WR;
`endif

    state_e     state_q, state_d;
    cell_addr_t addr_q, addr_d;
    cell_addr_t sweep_q, sweep_d;
    logic       pend_draw_q, pend_draw_d;
    logic       keep_q, keep_d;
    logic       pend_clear_q, pend_clear_d;
    logic [7:0] drop_q, drop_d;
    logic       mem_we_q, mem_we_d;
    logic       mem_wdata_q, mem_wdata_d;
    cell_addr_t mem_addr_q, mem_addr_d;
    logic       busy_q, busy_d;
    logic       clear_done_q, clear_done_d;
`ifdef DRAW_TOGGLE_EN
    logic       mem_re_q, mem_re_d;
`endif

    cell_addr_t map_addr_s;
    cell_addr_t serve_addr_s;
    logic       in_range_s;
    logic       draw_ok_s;
    logic       draw_bad_s;
    logic       serve_s;
    logic       start_s;

    cell_addr_map u_map (
        .draw_x_i   (bus.drawX),
        .draw_y_i   (bus.drawY),
        .addr_o     (map_addr_s),
        .in_range_o (in_range_s)
    );

    assign draw_ok_s    = bus.drawPixel & in_range_s;
    assign draw_bad_s   = bus.drawPixel & ~in_range_s;
    assign serve_addr_s = draw_ok_s ? map_addr_s : addr_q;

    // Next-state, request capture and registered-output values.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sweep_d      = sweep_q;
        pend_draw_d  = pend_draw_q;
        keep_d       = keep_q;
        pend_clear_d = pend_clear_q | bus.clearCanvas;
        drop_d       = drop_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = 1'b0;
        mem_addr_d   = '0;
        clear_done_d = 1'b0;
        serve_s      = 1'b0;
        start_s      = 1'b0;
`ifdef DRAW_TOGGLE_EN
        mem_re_d     = 1'b0;
`endif

        // keep_q marks a pending draw that must survive the next clear start:
        // it arrived together with the clear request or during a sweep.
        if (draw_ok_s) begin
            pend_draw_d = 1'b1;
            addr_d      = map_addr_s;
            keep_d      = bus.clearCanvas | (state_q == CLEAR);
        end else if (bus.clearCanvas && (state_q != CLEAR)) begin
            keep_d = 1'b0;
        end else begin
            keep_d = keep_q;
        end

        if (draw_bad_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        case (state_q)
            IDLE, DRAW_WR: begin
                if (pend_clear_q) begin
                    start_s = 1'b1;
                end else if (bus.clearCanvas) begin
                    state_d = IDLE;
                end else if (draw_ok_s || pend_draw_q) begin
                    serve_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef DRAW_TOGGLE_EN
            DRAW_RD: begin
                state_d    = DRAW_WAIT;
                mem_addr_d = mem_addr_q;
            end
            DRAW_WAIT: begin
                state_d     = DRAW_WR;
                mem_we_d    = 1'b1;
                mem_addr_d  = mem_addr_q;
                mem_wdata_d = ~bus.mem_rdata;
            end
`endif
            CLEAR: begin
                pend_clear_d = 1'b0;
                if (bus.clearCanvas) begin
                    sweep_d    = '0;
                    mem_we_d   = 1'b1;
                    mem_addr_d = '0;
                end else if (is_last_cell(sweep_q)) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    sweep_d    = sweep_q + cell_addr_t'(1);
                    mem_we_d   = 1'b1;
                    mem_addr_d = sweep_q + cell_addr_t'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_s) begin
            state_d      = CLEAR;
            sweep_d      = '0;
            pend_clear_d = 1'b0;
            pend_draw_d  = pend_draw_q & keep_q;
            addr_d       = addr_q;
            mem_we_d     = 1'b1;
            mem_addr_d   = '0;
            mem_wdata_d  = 1'b0;
        end else if (serve_s) begin
            state_d     = SERVE_ST;
            pend_draw_d = 1'b0;
            mem_addr_d  = serve_addr_s;
`ifdef DRAW_TOGGLE_EN
            mem_re_d    = 1'b1;
`else
            mem_we_d    = 1'b1;
            mem_wdata_d = 1'b1;
`endif
        end else begin
            pend_draw_d = pend_draw_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State, queued request and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            sweep_q      <= '0;
            pend_draw_q  <= 1'b0;
            keep_q       <= 1'b0;
            pend_clear_q <= 1'b0;
            drop_q       <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 1'b0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
`ifdef DRAW_TOGGLE_EN
            mem_re_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sweep_q      <= sweep_d;
            pend_draw_q  <= pend_draw_d;
            keep_q       <= keep_d;
            pend_clear_q <= pend_clear_d;
            drop_q       <= drop_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
`ifdef DRAW_TOGGLE_EN
            mem_re_q     <= mem_re_d;
`endif
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.busy       = busy_q;
    assign bus.clear_done = clear_done_q;
    assign bus.drop_cnt   = drop_q;

`ifdef DRAW_TOGGLE_EN
    assign bus.mem_re = mem_re_q;
`else
    logic unused_rdata_s;
    assign unused_rdata_s = bus.mem_rdata;
    assign bus.mem_re     = 1'b0;
`endif

endmodule
